fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the main control decoder (controle).
//  - Holds the PC and fetches one 32-bit instruction at a time over a req/gnt/rvalid memory port.
//  - Presents the instruction, its opcode field [6:0] and its PC to decode with a valid/ready handshake.
//  - Accepts branch redirects from the datapath and discards any in-flight fetch.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/pc_reg.sv | 20 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, canonical NOP and fetch state encoding
package riscv_pkg;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with async reset, target load and +4 increment
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);
    logic [XLEN-1:0] pc_d, pc_q;
    always_comb pc_d = load ? target : inc ? pc_q + XLEN'(4) : pc_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
    end
    assign pc = pc_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch feeding decode over valid/ready,
// with branch redirect that discards any in-flight response.
module fetch_unit import riscv_pkg::*; #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [6:0]      if_opcode,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic            fetch_misalign
);
    fetch_state_e    state_d, state_q;
    logic            imem_req_d, imem_req_q;
    logic            if_valid_d, if_valid_q;
    logic [31:0]     if_instr_d, if_instr_q;
    logic [XLEN-1:0] if_pc_d, if_pc_q;
    logic            fetch_misalign_d, fetch_misalign_q;
    logic            pc_inc;
    logic [XLEN-1:0] pc;

    pc_reg #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (redirect),
        .inc    (pc_inc),
        .target ({redirect_target[XLEN-1:2], 2'b00}),
        .pc     (pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_inc     = 1'b0;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem_gnt) state_d = redirect ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (redirect) state_d = imem_rvalid ? S_REQ : S_DRAIN;
                else if (imem_rvalid) begin
                    state_d    = S_HOLD;
                    if_valid_d = 1'b1;
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc;
                end
            end
            S_HOLD: begin
                if (redirect) state_d = S_REQ;
                else if (if_ready) begin
                    state_d    = S_REQ;
                    pc_inc     = 1'b1;
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        // A redirect overrides whatever the state logic chose for the holding register
        if (redirect) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end
        imem_req_d       = state_d == S_REQ;
        fetch_misalign_d = redirect && |redirect_target[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            imem_req_q       <= 1'b0;
            if_valid_q       <= 1'b0;
            if_instr_q       <= NOP_INSTR;
            if_pc_q          <= RESET_PC;
            fetch_misalign_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            imem_req_q       <= imem_req_d;
            if_valid_q       <= if_valid_d;
            if_instr_q       <= if_instr_d;
            if_pc_q          <= if_pc_d;
            fetch_misalign_q <= fetch_misalign_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_opcode      = if_instr_q[6:0];
    assign if_pc          = if_pc_q;
    assign fetch_misalign = fetch_misalign_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand sequences for PC wrap and async reset
module tb_fetch_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        req0, gnt0, rv0, val0, rdy0, red0, mis0;
    logic [31:0] addr0, rdata0, instr0, pc0, tgt0;
    logic [6:0]  opc0;
    logic        req1, gnt1, rv1, val1, rdy1, red1, mis1;
    logic [31:0] addr1, rdata1, instr1, pc1, tgt1;
    logic [6:0]  opc1;

    fetch_unit u0 (
        .clk(clk), .reset(rst0), .imem_req(req0), .imem_addr(addr0), .imem_gnt(gnt0),
        .imem_rvalid(rv0), .imem_rdata(rdata0), .if_valid(val0), .if_ready(rdy0),
        .if_instr(instr0), .if_opcode(opc0), .if_pc(pc0), .redirect(red0),
        .redirect_target(tgt0), .fetch_misalign(mis0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u1 (
        .clk(clk), .reset(rst1), .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt1),
        .imem_rvalid(rv1), .imem_rdata(rdata1), .if_valid(val1), .if_ready(rdy1),
        .if_instr(instr1), .if_opcode(opc1), .if_pc(pc1), .redirect(red1),
        .redirect_target(tgt1), .fetch_misalign(mis1)
    );

    typedef struct {
        logic        red;
        logic [31:0] tgt;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        val;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t tbl[28];
    int   passed = 0;
    int   total  = 0;

    function automatic vec_t mk(logic red, logic [31:0] tgt, logic gnt, logic rv, logic [31:0] rdata,
                                logic rdy, logic req, logic [31:0] addr, logic val,
                                logic [31:0] instr, logic [31:0] pc, logic mis);
        vec_t v;
        v.red = red; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy;
        v.req = req; v.addr = addr; v.val = val; v.instr = instr; v.pc = pc; v.mis = mis;
        return v;
    endfunction

    // Packed as {req, addr, valid, instr, opcode, pc, misalign}
    task automatic chk(input string name, input logic [105:0] act, input logic [105:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got req=%0b addr=%h val=%0b instr=%h opc=%b pc=%h mis=%0b, want req=%0b addr=%h val=%0b instr=%h opc=%b pc=%h mis=%0b",
                      name, act[105], act[104:73], act[72], act[71:40], act[39:33], act[32:1], act[0],
                      exp[105], exp[104:73], exp[72], exp[71:40], exp[39:33], exp[32:1], exp[0]);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [105:0] pack_exp(logic req, logic [31:0] addr, logic val,
                                             logic [31:0] instr, logic [31:0] pc, logic mis);
        return {req, addr, val, instr, instr[6:0], pc, mis};
    endfunction

    initial begin
        tbl[0]  = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h0,   0, 32'h13,       32'h0,   0);
        tbl[1]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h0,   0, 32'h13,       32'h0,   0);
        tbl[2]  = mk(0, 32'h0,   0, 1, 32'h33,       0, 0, 32'h0,   1, 32'h33,       32'h0,   0);
        tbl[3]  = mk(0, 32'h0,   0, 0, 32'h0,        1, 1, 32'h4,   0, 32'h13,       32'h0,   0);
        tbl[4]  = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h4,   0, 32'h13,       32'h0,   0);
        tbl[5]  = mk(0, 32'h0,   0, 1, 32'h00A12023, 0, 0, 32'h4,   1, 32'h00A12023, 32'h4,   0);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(0, 32'h0, 0, 0, 32'h0,       0, 0, 32'h4,   1, 32'h00A12023, 32'h4,   0);
        tbl[11] = mk(0, 32'h0,   0, 0, 32'h0,        1, 1, 32'h8,   0, 32'h13,       32'h4,   0);
        tbl[12] = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h8,   0, 32'h13,       32'h4,   0);
        tbl[13] = mk(1, 32'h100, 0, 0, 32'h0,        0, 0, 32'h100, 0, 32'h13,       32'h4,   0);
        tbl[14] = mk(0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h100, 0, 32'h13,       32'h4,   0);
        tbl[15] = mk(0, 32'h0,   0, 1, 32'h3,        0, 1, 32'h100, 0, 32'h13,       32'h4,   0);
        tbl[16] = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h100, 0, 32'h13,       32'h4,   0);
        tbl[17] = mk(0, 32'h0,   0, 1, 32'h00002003, 0, 0, 32'h100, 1, 32'h00002003, 32'h100, 0);
        tbl[18] = mk(1, 32'h40,  0, 0, 32'h0,        1, 1, 32'h40,  0, 32'h13,       32'h100, 0);
        tbl[19] = mk(1, 32'h102, 0, 0, 32'h0,        0, 1, 32'h100, 0, 32'h13,       32'h100, 1);
        tbl[20] = mk(0, 32'h0,   0, 0, 32'h0,        0, 1, 32'h100, 0, 32'h13,       32'h100, 0);
        tbl[21] = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h100, 0, 32'h13,       32'h100, 0);
        tbl[22] = mk(0, 32'h0,   0, 1, 32'h00000063, 0, 0, 32'h100, 1, 32'h00000063, 32'h100, 0);
        tbl[23] = mk(0, 32'h0,   0, 0, 32'h0,        1, 1, 32'h104, 0, 32'h13,       32'h100, 0);
        tbl[24] = mk(1, 32'h200, 1, 0, 32'h0,        0, 0, 32'h200, 0, 32'h13,       32'h100, 0);
        tbl[25] = mk(0, 32'h0,   0, 1, 32'h33,       0, 1, 32'h200, 0, 32'h13,       32'h100, 0);
        tbl[26] = mk(0, 32'h0,   1, 0, 32'h0,        0, 0, 32'h200, 0, 32'h13,       32'h100, 0);
        tbl[27] = mk(1, 32'h300, 0, 1, 32'h33,       0, 1, 32'h300, 0, 32'h13,       32'h100, 0);

        rst0 = 1'b1; rst1 = 1'b1;
        {gnt0, rv0, rdy0, red0} = '0; rdata0 = '0; tgt0 = '0;
        {gnt1, rv1, rdy1, red1} = '0; rdata1 = '0; tgt1 = '0;
        tick;
        chk("reset_u0", {req0, addr0, val0, instr0, opc0, pc0, mis0}, pack_exp(0, 32'h0, 0, 32'h13, 32'h0, 0));
        chk("reset_u1", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(0, 32'hFFFF_FFFC, 0, 32'h13, 32'hFFFF_FFFC, 0));
        rst0 = 1'b0; rst1 = 1'b0;

        for (int i = 0; i < 28; i++) begin
            red0 = tbl[i].red; tgt0 = tbl[i].tgt; gnt0 = tbl[i].gnt;
            rv0 = tbl[i].rv; rdata0 = tbl[i].rdata; rdy0 = tbl[i].rdy;
            tick;
            chk($sformatf("vec%0d", i), {req0, addr0, val0, instr0, opc0, pc0, mis0},
                pack_exp(tbl[i].req, tbl[i].addr, tbl[i].val, tbl[i].instr, tbl[i].pc, tbl[i].mis));
        end
        {gnt0, rv0, rdy0, red0} = '0;
        total++;
        if (opc0 === 7'b0010011) passed++;
        else $display("FAIL nop_opcode: got %b want 0010011", opc0);

        // u1 has been idling in S_REQ at the reset PC; fetch one instruction and check the wrap
        chk("wrap_req", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(1, 32'hFFFF_FFFC, 0, 32'h13, 32'hFFFF_FFFC, 0));
        gnt1 = 1'b1; tick; gnt1 = 1'b0;
        rv1 = 1'b1; rdata1 = 32'h0000_0033; tick; rv1 = 1'b0;
        chk("wrap_hold", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(0, 32'hFFFF_FFFC, 1, 32'h33, 32'hFFFF_FFFC, 0));
        rdy1 = 1'b1; tick; rdy1 = 1'b0;
        chk("wrap_addr", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(1, 32'h0, 0, 32'h13, 32'hFFFF_FFFC, 0));
        gnt1 = 1'b1; tick; gnt1 = 1'b0;
        chk("wrap_wait", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(0, 32'h0, 0, 32'h13, 32'hFFFF_FFFC, 0));
        #2 rst1 = 1'b1;
        #1;
        chk("async_reset", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(0, 32'hFFFF_FFFC, 0, 32'h13, 32'hFFFF_FFFC, 0));
        tick;
        rst1 = 1'b0;
        tick;
        chk("after_reset", {req1, addr1, val1, instr1, opc1, pc1, mis1},
            pack_exp(1, 32'hFFFF_FFFC, 0, 32'h13, 32'hFFFF_FFFC, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
